// File: rtl/col_ro_pkg.sv
// Shared types and constants for the pixel column readout controller.
// Optional macro COL_TRAILER_EN adds the TRAIL state (per-trigger trailer word).
package col_ro_pkg;

    localparam int DATA_W   = 46;
    localparam int HIT_W    = 5;
    localparam int COL_W    = 4;
    localparam int MAX_HITS = 16;
    localparam int TIMER_W  = 4;

    // Trailer word layout, MSB-first: {hitCnt, colAddr, zero padding}
    localparam int TRL_HITCNT_LSB = DATA_W - HIT_W;          // bits 45:41
    localparam int TRL_COL_LSB    = TRL_HITCNT_LSB - COL_W;  // bits 40:37

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_PUSH   = 3'd3,
        ST_POP    = 3'd4,
        ST_GAP    = 3'd5
`ifdef COL_TRAILER_EN
        ,
        ST_TRAIL  = 3'd6
`endif
    } colState_t;

    // The column can report more hits than it physically holds; never read past 16.
    function automatic logic [HIT_W-1:0] clampHits(input logic [HIT_W-1:0] hits);
        return (hits > HIT_W'(MAX_HITS)) ? HIT_W'(MAX_HITS) : hits;
    endfunction

    // Assemble a trailer word from the hit count and column address.
    function automatic logic [DATA_W-1:0] trailerWord(input logic [HIT_W-1:0] hitCnt,
                                                      input logic [COL_W-1:0] colAddr);
        logic [DATA_W-1:0] w;
        w = '0;
        w[TRL_HITCNT_LSB +: HIT_W] = hitCnt;
        w[TRL_COL_LSB +: COL_W]    = colAddr;
        return w;
    endfunction

endpackage

// File: rtl/col_trig_counter.sv
// Pending-trigger counter: counts accepted l1a requests not yet served and
// raises a sticky overflow flag when a request arrives with no room left.
module col_trig_counter #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    input  logic             deq,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [CNT_W-1:0] countReg;
    logic [CNT_W-1:0] countNext;
    logic             ovfReg;
    logic             dropNow;

    // Next count; a simultaneous request and dequeue cancel out and never drop.
    always_comb begin
        countNext = countReg;
        dropNow   = 1'b0;
        if (inc && !deq) begin
            if (countReg == CNT_W'(DEPTH)) begin
                dropNow = 1'b1;
            end else begin
                countNext = countReg + 1'b1;
            end
        end else if (deq && !inc) begin
            countNext = countReg - 1'b1;
        end
    end

    // Count and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            countReg <= '0;
            ovfReg   <= 1'b0;
        end else begin
            countReg <= countNext;
            if (dropNow) begin
                ovfReg <= 1'b1;
            end
        end
    end

    assign count = countReg;
    assign ovf   = ovfReg;

endmodule

// File: rtl/col_read_ctrl.sv
// Column readout controller: on each trigger waits for the column chain to
// settle, samples the hit count, then streams up to 16 hit words out over a
// valid/ready port, popping the column once per accepted word.
// Optional macro COL_TRAILER_EN: append a {hitCnt, colAddr} trailer per trigger.
module col_read_ctrl
    import col_ro_pkg::*;
#(
    parameter int SETTLE    = 4,
    parameter int READGAP   = 2,
    parameter int TRIGDEPTH = 4
) (
    input  logic              clkRO,
    input  logic              reset,
    input  logic [COL_W-1:0]  colAddrIn,
    input  logic              l1a,
    input  logic [DATA_W-1:0] dnData,
    input  logic [HIT_W-1:0]  dnHits,
    output logic              dnRead,
    output logic [DATA_W-1:0] outData,
    output logic              outValid,
    input  logic              outReady,
    output logic              outTrailer,
    output logic              busy,
    output logic              trigOvf
);

    localparam int CNT_W = $clog2(TRIGDEPTH + 1);

    colState_t          stateReg,     stateNext;
    logic [TIMER_W-1:0] timerReg,     timerNext;
    logic [HIT_W-1:0]   remainingReg, remainingNext;
    logic [HIT_W-1:0]   hitCntReg,    hitCntNext;
    logic [DATA_W-1:0]  outDataReg,   outDataNext;
    logic               outValidReg,  outValidNext;
    logic               outTrailerReg, outTrailerNext;
    logic               dnReadNext;
    logic               dequeue;
    logic [CNT_W-1:0]   trigCount;
    logic [HIT_W-1:0]   sampledHits;

    assign dequeue     = (stateReg == ST_IDLE) && (trigCount != '0);
    assign sampledHits = clampHits(dnHits);

    col_trig_counter #(
        .DEPTH (TRIGDEPTH)
    ) u_trigCounter (
        .clk   (clkRO),
        .srst  (reset),
        .inc   (l1a),
        .deq   (dequeue),
        .count (trigCount),
        .ovf   (trigOvf)
    );

    // Next-state, datapath and strobe logic; registers hold unless a state says otherwise.
    always_comb begin
        stateNext      = stateReg;
        timerNext      = timerReg;
        remainingNext  = remainingReg;
        hitCntNext     = hitCntReg;
        outDataNext    = outDataReg;
        outValidNext   = outValidReg;
        outTrailerNext = outTrailerReg;
        dnReadNext     = 1'b0;
        unique case (stateReg)
            ST_IDLE: begin
                if (dequeue) begin
                    timerNext = TIMER_W'(SETTLE - 1);
                    stateNext = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timerReg == '0) begin
                    stateNext = ST_SAMPLE;
                end else begin
                    timerNext = timerReg - 1'b1;
                end
            end
            ST_SAMPLE: begin
                remainingNext = sampledHits;
                hitCntNext    = sampledHits;
                if (sampledHits == '0) begin
`ifdef COL_TRAILER_EN
                    outDataNext    = trailerWord(sampledHits, colAddrIn);
                    outValidNext   = 1'b1;
                    outTrailerNext = 1'b1;
                    stateNext      = ST_TRAIL;
`else
                    stateNext      = ST_IDLE;
`endif
                end else begin
                    outDataNext  = dnData;
                    outValidNext = 1'b1;
                    stateNext    = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (outValidReg && outReady) begin
                    outValidNext = 1'b0;
                    stateNext    = ST_POP;
                end
            end
            ST_POP: begin
                dnReadNext    = 1'b1;
                remainingNext = remainingReg - 1'b1;
                timerNext     = TIMER_W'(READGAP - 1);
                stateNext     = ST_GAP;
            end
            ST_GAP: begin
                if (timerReg != '0) begin
                    timerNext = timerReg - 1'b1;
                end else if (remainingReg != '0) begin
                    outDataNext  = dnData;
                    outValidNext = 1'b1;
                    stateNext    = ST_PUSH;
                end else begin
`ifdef COL_TRAILER_EN
                    outDataNext    = trailerWord(hitCntReg, colAddrIn);
                    outValidNext   = 1'b1;
                    outTrailerNext = 1'b1;
                    stateNext      = ST_TRAIL;
`else
                    stateNext      = ST_IDLE;
`endif
                end
            end
`ifdef COL_TRAILER_EN
            ST_TRAIL: begin
                if (outValidReg && outReady) begin
                    outValidNext   = 1'b0;
                    outTrailerNext = 1'b0;
                    stateNext      = ST_IDLE;
                end
            end
`endif
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clkRO) begin
        if (reset) begin
            stateReg      <= ST_IDLE;
            timerReg      <= '0;
            remainingReg  <= '0;
            hitCntReg     <= '0;
            outDataReg    <= '0;
            outValidReg   <= 1'b0;
            outTrailerReg <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            timerReg      <= timerNext;
            remainingReg  <= remainingNext;
            hitCntReg     <= hitCntNext;
            outDataReg    <= outDataNext;
            outValidReg   <= outValidNext;
            outTrailerReg <= outTrailerNext;
        end
    end

    // The pop strobe is a pure decode of POP, so it can only last one cycle.
    assign dnRead   = dnReadNext;
    assign outData  = outDataReg;
    assign outValid = outValidReg;
    assign busy     = (stateReg != ST_IDLE) || (trigCount != '0);

`ifdef COL_TRAILER_EN
    assign outTrailer = outTrailerReg;
`else
    // Without trailers the column address and hit count have no consumer.
    logic unusedSink;
    assign unusedSink = ^{colAddrIn, hitCntReg, outTrailerReg};
    assign outTrailer = 1'b0;
`endif

endmodule

// File: doc/col_read_ctrl.md
COL_READ_CTRL -- requirements
Module: col_read_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 4: cycles waited after trigger dequeue before sampling the column chain (range 1..15).
REQ-002 SHALL have parameter READGAP, default 2: cycles waited after each dnRead pulse for the 16-pixel chain to re-ripple (range 1..15).
REQ-003 SHALL have parameter TRIGDEPTH, default 4: maximum pending triggers.
REQ-004 SHALL have ports: clkRO  in  1  readout clock; all logic on its rising edge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: colAddrIn  in  4  column address, copied into trailer.
REQ-007 SHALL have ports: l1a  in  1  single-cycle trigger request.
REQ-008 SHALL have ports: dnData  in  46  current head hit word of the pixel column.
REQ-009 SHALL have ports: dnHits  in  5  hit count reported by the pixel column.
REQ-010 SHALL have ports: dnRead  out  1  single-cycle pop strobe to the pixel column.
REQ-011 SHALL have ports: outData  out  46; outValid  out  1; outReady  in  1: valid/ready word stream.
REQ-012 SHALL have ports: outTrailer  out  1  marks current outData as trailer; busy  out  1  state not IDLE or triggers pending; trigOvf  out  1  sticky trigger-drop flag.

Function
REQ-013 SHALL keep a pending-trigger counter (0..TRIGDEPTH): +1 on l1a, -1 on dequeue; simultaneous l1a and dequeue leaves it unchanged.
REQ-014 SHALL drop l1a when counter = TRIGDEPTH and no dequeue that cycle, and set trigOvf until reset.
REQ-015 SHALL implement states IDLE, SETTLE, SAMPLE, PUSH, POP, GAP, TRAIL.
REQ-016 IDLE: counter > 0 -> dequeue, load timer SETTLE-1, go SETTLE.
REQ-017 SETTLE: decrement timer; at 0 go SAMPLE.
REQ-018 SAMPLE: latch remaining = min(dnHits,16) and hitCnt = same; if 0 go TRAIL (macro on) or IDLE (macro off); else load outData <= dnData, outValid <= 1, go PUSH.
REQ-019 PUSH: hold outData/outValid stable while outReady low; on outValid&outReady clear outValid, go POP.
REQ-020 POP: dnRead = 1 for exactly this cycle, decrement remaining, load timer READGAP-1, go GAP.
REQ-021 GAP: at timer 0: remaining > 0 -> capture dnData, outValid <= 1, go PUSH; else TRAIL (macro on) or IDLE.
REQ-022 dnRead SHALL never assert outside POP; at most hitCnt pulses per trigger.
REQ-023 With idle controller, empty queue, outReady high: outValid SHALL first rise exactly SETTLE+3 cycles after the l1a cycle.
REQ-024 busy SHALL be high whenever state != IDLE or counter > 0.

Reset
REQ-025 On reset (including mid-sequence): state IDLE, counter 0, trigOvf 0, dnRead 0, outValid 0, outTrailer 0, outData 0, busy 0, effective next cycle; an l1a in a reset cycle is ignored.

Configuration
REQ-026 Macro COL_TRAILER_EN defined: TRAIL state presents outData = {hitCnt (5), colAddrIn (4), 37'b0} MSB-first, outTrailer = 1, outValid = 1, waits for handshake, then IDLE; one trailer per trigger, including zero-hit triggers.
REQ-027 COL_TRAILER_EN undefined: no TRAIL state, outTrailer tied 0, zero-hit triggers produce no output.

Structure
REQ-028 Package col_ro_pkg SHALL hold the state enum, data width 46, hit width 5, max hits 16, trailer field positions.
REQ-029 Pending-trigger counter with overflow flag SHALL be a sub-module col_trig_counter.

Verification
REQ-030 SETTLE=4, dnHits=3, outReady high, single l1a at cycle 0 -> outValid at cycle 7; 3 hit words, 3 dnRead pulses READGAP+2 cycles apart, then trailer {3,col}.
REQ-031 dnHits=0 -> zero dnRead pulses; one trailer with hitCnt 0 (macro on), no output (macro off).
REQ-032 outReady held low 20 cycles during PUSH -> outData stable, dnRead stays 0, resumes after ready.
REQ-033 6 back-to-back l1a, TRIGDEPTH=4, controller busy -> exactly 5 triggers served (1 dequeued + 4 queued), trigOvf = 1.
REQ-034 dnHits=20 -> exactly 16 words and 16 dnRead pulses.
REQ-035 reset asserted in GAP with remaining 2 -> next cycle outputs at reset values, later l1a restarts cleanly.
